// File: rtl/fsram_read_ctrl_pkg.sv
// Shared FSRAM definitions: bank geometry defaults and the read controller state encoding.
// The FSRAM write controller imports the same package so both sides agree on word layout.
package fsram_read_ctrl_pkg;

  localparam int SRAM_NUM_DEF = 8;
  localparam int ADDR_W_DEF   = 12;
  localparam int BANK_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fsram_rd_fifo.sv
// Synchronous output buffer for FSRAM rows; head is shown on o_data while non-empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module fsram_rd_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_rd = i_pop && (r_count != (PTR_W+1)'(0));
  assign w_wr = i_push && ((r_count != (PTR_W+1)'(DEPTH)) || w_rd);

  // Pointer and occupancy bookkeeping; a same-cycle push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= PTR_W'(0);
      r_rptr  <= PTR_W'(0);
      r_count <= (PTR_W+1)'(0);
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = (r_count != (PTR_W+1)'(0)) ? r_mem[r_rptr] : {WIDTH{1'b0}};
  assign o_count = r_count;

endmodule

// File: rtl/fsram_read_ctrl.sv
// Burst reader for the parallel FSRAM banks: issues port-B reads and streams rows out
// through a small buffer, throttling reads so buffered plus in-flight rows never exceed it.
module fsram_read_ctrl
  import fsram_read_ctrl_pkg::*;
#(
  parameter int SRAM_NUM   = SRAM_NUM_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W:0]            length,
  output logic                       busy,
  output logic                       done,
  output logic                       CENB,
  output logic [SRAM_NUM-1:0]        WENB,
  output logic [ADDR_W-1:0]          AB,
  input  logic [SRAM_NUM*BANK_W-1:0] QB,
  output logic [SRAM_NUM*BANK_W-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int DW    = SRAM_NUM * BANK_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic              r_issue;
  logic              r_inflight;
  logic              r_done;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W:0]   w_rem_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_cnt_nxt;
  logic [CNT_W:0]    w_occ_nxt;
  logic              w_accept;
  logic              w_zero_start;
  logic              w_pop;
  logic              w_issue_nxt;
  logic              w_done_nxt;

  assign w_accept     = (r_state == ST_IDLE) && start && (length != (ADDR_W+1)'(0));
  assign w_zero_start = (r_state == ST_IDLE) && start && (length == (ADDR_W+1)'(0));
  assign out_valid    = (w_count != CNT_W'(0));
  assign w_pop        = out_valid && out_ready;

  fsram_rd_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (QB),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_count (w_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DRAIN ends on the cycle the final buffered row is popped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_READ;
        else          w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (r_issue && (r_rem == (ADDR_W+1)'(1))) w_state_nxt = ST_DRAIN;
        else                                      w_state_nxt = ST_READ;
      end
      ST_DRAIN: begin
        if (!r_inflight && (w_cnt_nxt == (CNT_W+1)'(0))) w_state_nxt = ST_IDLE;
        else                                              w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Look-ahead for the registered read strobe: occupancy next cycle includes the row now in flight.
  always_comb begin
    w_cnt_nxt = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
    w_occ_nxt = w_cnt_nxt + {{CNT_W{1'b0}}, r_issue};
    if (w_accept)     w_rem_nxt = length;
    else if (r_issue) w_rem_nxt = r_rem - (ADDR_W+1)'(1);
    else              w_rem_nxt = r_rem;
    w_issue_nxt = (w_state_nxt == ST_READ) && (w_rem_nxt != (ADDR_W+1)'(0)) &&
                  (w_occ_nxt < DEPTH_L);
    w_done_nxt  = w_zero_start || ((r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE));
  end

  // Datapath registers; the in-flight flag marks the cycle QB must be captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue    <= 1'b0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_rem      <= (ADDR_W+1)'(0);
      r_addr     <= ADDR_W'(0);
    end else begin
      r_issue    <= w_issue_nxt;
      r_inflight <= r_issue;
      r_done     <= w_done_nxt;
      r_rem      <= w_rem_nxt;
      if (w_accept)     r_addr <= base_addr;
      else if (r_issue) r_addr <= r_addr + ADDR_W'(1);
      else              r_addr <= r_addr;
    end
  end

  // Output decode.
  always_comb begin
    busy = (r_state != ST_IDLE);
    done = r_done;
    CENB = ~r_issue;
    WENB = {SRAM_NUM{1'b1}};
    AB   = r_addr;
  end

endmodule

// File: tb/tb_fsram_read_ctrl.sv
// Scoreboard bench for fsram_read_ctrl: a behavioural FSRAM model feeds QB, expected
// addresses and rows are queued at each accepted start and checked by a negedge monitor.
module tb_fsram_read_ctrl;

  localparam int SRAM_NUM   = 8;
  localparam int ADDR_W     = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = SRAM_NUM * 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              CENB;
  logic [SRAM_NUM-1:0] WENB;
  logic [ADDR_W-1:0] AB;
  logic [DW-1:0]     QB;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;

  fsram_read_ctrl #(
    .SRAM_NUM   (SRAM_NUM),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .CENB      (CENB),
    .WENB      (WENB),
    .AB        (AB),
    .QB        (QB),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [15:0] salt;

  // Content of one FSRAM row as a pure function of its address.
  function automatic logic [DW-1:0] row_of(input logic [ADDR_W-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < SRAM_NUM; i++)
      r[i*16 +: 16] = ((16'(a) * 16'd31) + (16'(i) * 16'h1357)) ^ salt;
    return r;
  endfunction

  // FSRAM port-B model: one-cycle read latency, garbage on QB otherwise.
  always @(posedge clk) begin
    if (CENB === 1'b0) QB <= row_of(AB);
    else               QB <= DW'({$urandom, $urandom, $urandom, $urandom});
  end

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } row_t;

  row_t              exp_rows[$];
  logic [ADDR_W-1:0] exp_addr[$];
  bit active = 1'b0, zl_pending = 1'b0, done_exp = 1'b0;
  bit prev_hold = 1'b0, fv_track = 1'b0, rand_ready = 1'b0;
  logic [DW-1:0] prev_data;
  int cenb_lows = 0, xfers = 0, first_valid_cyc = -1;
  int run_c = 0, last_c = -10, max_cenb_run = 0;
  int run_x = 0, last_x = -10, max_xfer_run = 0;

  // Monitor: pops the scoreboard on every read strobe and every stream transfer.
  always @(negedge clk) begin : monitor
    row_t r;
    logic [ADDR_W-1:0] a;
    bit nd;
    if (rst_n) begin
      if (prev_hold) begin
        check(out_valid == 1'b1, "hold_valid", out_valid, 1);
        check(out_data == prev_data, "hold_data", out_data, prev_data);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (fv_track && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid) check(busy == 1'b1, "busy_while_valid", busy, 1);
      if (!CENB) begin
        cenb_lows++;
        run_c = (last_c == cyc - 1) ? run_c + 1 : 1;
        last_c = cyc;
        if (run_c > max_cenb_run) max_cenb_run = run_c;
        check(WENB == {SRAM_NUM{1'b1}}, "WENB_read", WENB, {SRAM_NUM{1'b1}});
        if (exp_addr.size() == 0) check(1'b0, "unexpected_read", AB, 0);
        else begin
          a = exp_addr.pop_front();
          check(AB == a, "AB", AB, a);
        end
      end
      if (done || done_exp) begin
        check(done == done_exp, "done", done, done_exp);
        if (done_exp) begin
          check(busy == 1'b0, "busy_at_done", busy, 0);
          active = 1'b0;
        end
      end
      nd = 1'b0;
      if (out_valid && out_ready) begin
        xfers++;
        run_x = (last_x == cyc - 1) ? run_x + 1 : 1;
        last_x = cyc;
        if (run_x > max_xfer_run) max_xfer_run = run_x;
        if (exp_rows.size() == 0) check(1'b0, "unexpected_row", out_data, 0);
        else begin
          r = exp_rows.pop_front();
          check(out_data == r.data, "row", out_data, r.data);
          nd = r.last;
        end
      end
      if (zl_pending) begin
        nd = 1'b1;
        zl_pending = 1'b0;
      end
      done_exp = nd;
    end
  end

  // Random backpressure during the randomized phase.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted start: queue the addresses and rows the burst must produce.
  task automatic issue_burst(input logic [ADDR_W-1:0] b, input int len);
    row_t r;
    logic [ADDR_W-1:0] a;
    start = 1'b1;
    base_addr = b;
    length = (ADDR_W+1)'(len);
    if (len == 0) zl_pending = 1'b1;
    else begin
      active = 1'b1;
      for (int k = 0; k < len; k++) begin
        a = b + ADDR_W'(k);
        exp_addr.push_back(a);
        r.data = row_of(a);
        r.last = (k == len - 1);
        exp_rows.push_back(r);
      end
    end
    tick();
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    length = (ADDR_W+1)'($urandom);
  endtask

  // Start pulse issued while a burst is known to be running; must have no effect.
  task automatic pulse_ignored(input logic [ADDR_W-1:0] b, input int len);
    start = 1'b1;
    base_addr = b;
    length = (ADDR_W+1)'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((active || zl_pending || done_exp) && n < bound) begin
      tick();
      n++;
    end
    if (active || zl_pending || done_exp) check(1'b0, "idle_timeout", n, bound);
    tick();
  endtask

  task automatic reset_check(input string tag);
    check(CENB == 1'b1, {tag, "_CENB"}, CENB, 1);
    check(WENB == {SRAM_NUM{1'b1}}, {tag, "_WENB"}, WENB, {SRAM_NUM{1'b1}});
    check(AB == '0, {tag, "_AB"}, AB, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(done == 1'b0, {tag, "_done"}, done, 0);
    check(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
    check(out_data == '0, {tag, "_out_data"}, out_data, 0);
  endtask

  task automatic clear_model();
    exp_rows.delete();
    exp_addr.delete();
    active = 1'b0;
    zl_pending = 1'b0;
    done_exp = 1'b0;
    prev_hold = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c0, x0, len;
    logic [ADDR_W-1:0] b;
    salt = 16'($urandom);
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b0;
    #2;
    reset_check("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Full-throughput burst: consecutive reads and transfers, first row two edges after the sampling edge.
    out_ready = 1'b1;
    fv_track = 1'b1;
    first_valid_cyc = -1;
    max_cenb_run = 0;
    max_xfer_run = 0;
    t0 = cyc;
    issue_burst(12'h010, 8);
    wait_idle(100);
    fv_track = 1'b0;
    check(first_valid_cyc == t0 + 3, "first_valid_latency", first_valid_cyc, t0 + 3);
    check(max_cenb_run == 8, "ab_consecutive", max_cenb_run, 8);
    check(max_xfer_run == 8, "throughput", max_xfer_run, 8);

    // Address wrap at the top of the FSRAM.
    issue_burst(12'hFFE, 4);
    wait_idle(100);

    // Backpressure: reads stop once the buffer plus in-flight rows reach its depth.
    out_ready = 1'b0;
    c0 = cenb_lows;
    x0 = xfers;
    issue_burst(12'h400, 16);
    repeat (10) tick();
    check(cenb_lows - c0 == FIFO_DEPTH, "stall_reads", cenb_lows - c0, FIFO_DEPTH);
    out_ready = 1'b1;
    wait_idle(200);
    check(xfers - x0 == 16, "stall_rows", xfers - x0, 16);

    // Zero-length request: done only, no reads, no data.
    c0 = cenb_lows;
    issue_burst(12'h123, 0);
    for (int i = 0; i < 3; i++) begin
      check(CENB == 1'b1, "zero_len_CENB", CENB, 1);
      check(out_valid == 1'b0, "zero_len_valid", out_valid, 0);
      check(busy == 1'b0, "zero_len_busy", busy, 0);
      tick();
    end
    check(cenb_lows == c0, "zero_len_reads", cenb_lows - c0, 0);
    wait_idle(20);

    // Reset in the middle of a burst, then a short clean burst.
    x0 = xfers;
    issue_burst(12'h200, 12);
    for (int i = 0; i < 40 && (xfers - x0) < 5; i++) tick();
    #1;
    rst_n = 1'b0;
    #1;
    reset_check("midreset");
    clear_model();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    x0 = xfers;
    issue_burst(12'h7F0, 3);
    wait_idle(100);
    repeat (4) tick();
    check(xfers - x0 == 3, "post_reset_rows", xfers - x0, 3);

    // Re-asserted start during a burst is ignored.
    issue_burst(12'h100, 10);
    repeat (3) tick();
    pulse_ignored(12'h300, 5);
    wait_idle(100);

    // Randomized bursts with backpressure and stray starts.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      b = ADDR_W'($urandom);
      issue_burst(b, len);
      if (len >= 3 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, len - 2)) tick();
        pulse_ignored(ADDR_W'($urandom), int'($urandom_range(0, 30)));
      end
      wait_idle(400);
    end
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (4) tick();

    check(exp_rows.size() == 0, "rows_left", exp_rows.size(), 0);
    check(exp_addr.size() == 0, "reads_left", exp_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsram_read_ctrl.md
FSRAM_READ_CTRL -- requirements
Module: fsram_read_ctrl

Interface
REQ-001 SHALL have parameter SRAM_NUM, default 8, number of parallel 16-bit FSRAM banks read as one word.
REQ-002 SHALL have parameter ADDR_W, default 12, FSRAM address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a burst read.
REQ-007 SHALL have port base_addr  input  ADDR_W  first row address, sampled on accepted start.
REQ-008 SHALL have port length  input  ADDR_W+1  rows to read (0..4096), sampled on accepted start.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when last row is handed off.
REQ-011 SHALL have port CENB  output  1  FSRAM port-B chip enable, active-low.
REQ-012 SHALL have port WENB  output  SRAM_NUM  FSRAM port-B write enables, active-low; held all-ones (read only).
REQ-013 SHALL have port AB  output  ADDR_W  FSRAM port-B address, broadcast to all banks.
REQ-014 SHALL have port QB  input  SRAM_NUM*16  FSRAM port-B read data, valid one cycle after CENB low.
REQ-015 SHALL have port out_data  output  SRAM_NUM*16  row data toward compute engine.
REQ-016 SHALL have ports out_valid  output  1  and out_ready  input  1  forming a valid/ready stream.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start with length>0; READ->DRAIN after last read issued; DRAIN->IDLE when FIFO empty and no read in flight.
REQ-018 SHALL, on start with length==0 in IDLE, pulse done the next cycle, issue no reads, busy never high.
REQ-019 SHALL ignore start while busy; base_addr/length changes during busy SHALL have no effect.
REQ-020 SHALL drive CENB low in a cycle only if state is READ and (FIFO count + reads in flight) < FIFO_DEPTH.
REQ-021 SHALL present AB = base_addr + k on the k-th issued read, incrementing modulo 2^ADDR_W (4095 wraps to 0).
REQ-022 SHALL capture QB into the FIFO exactly one cycle after each CENB-low cycle; no row dropped or duplicated.
REQ-023 SHALL drive out_valid high whenever FIFO non-empty; out_data = FIFO head; transfer occurs when out_valid&&out_ready.
REQ-024 SHALL hold out_data stable while out_valid high and out_ready low.
REQ-025 SHALL sustain one row per cycle throughput when out_ready held high; first out_valid 2 cycles after start.
REQ-026 SHALL handle simultaneous FIFO push and pop in one cycle, count unchanged, no loss when full.
REQ-027 SHALL pulse done in the cycle after the final row transfer; busy deasserts that same cycle.
REQ-028 SHALL output rows in address order.

Reset
REQ-029 SHALL, on rst_n low at any time, asynchronously force: state IDLE, CENB=1, WENB=all-ones, AB=0, busy=0, done=0, out_valid=0, out_data=0, FIFO empty, counters 0.
REQ-030 SHALL discard any in-flight burst on reset mid-operation; post-reset QB capture SHALL not occur.

Structure
REQ-031 SHALL place SRAM_NUM, ADDR_W and state encodings in the shared defines/package used by the FSRAM write controller.
REQ-032 SHALL implement the output buffer as one sub-module fsram_rd_fifo (synchronous, width SRAM_NUM*16, depth FIFO_DEPTH, count output).

Verification
REQ-033 SHALL verify: base_addr=0x010, length=8, out_ready=1 -> AB 0x010..0x017 on consecutive cycles, 8 rows in order, done 1 cycle after 8th transfer.
REQ-034 SHALL verify: base_addr=0xFFE, length=4 -> AB sequence 0xFFE,0xFFF,0x000,0x001.
REQ-035 SHALL verify: length=16, out_ready low for 10 cycles after start -> CENB low exactly 4 times, then stalls; all 16 rows delivered once ready rises.
REQ-036 SHALL verify: length=0 -> done pulse next cycle, CENB stays 1, out_valid stays 0.
REQ-037 SHALL verify: rst_n low at row 5 of length=12 -> all outputs at reset values immediately; new start with length=3 delivers exactly 3 rows.
REQ-038 SHALL verify: start re-asserted mid-burst with different base_addr -> ignored, original sequence completes unchanged.
